wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage sitting directly upstream of the 32x64 register bank; drives its write port (regwrite, register3, datain).
- Captures MEM-stage results in a pipeline register and formats load data (sign/zero extension, byte-lane select).
- Arbitrates the single bank write port between the in-order pipeline and a long-latency unit (mul/div), using a valid/ready handshake and a starvation guard.

Parameters:
- STARVE_LIMIT, 8, number of consecutive cycles the long-latency unit may be refused before the pipeline is stalled for one cycle (1..255).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mem_valid  in  1  MEM-stage entry valid.
- mem_regwrite  in  1  entry writes a register.
- mem_memtoreg  in  1  1 = load data result, 0 = ALU result.
- mem_rd  in  5  destination register.
- mem_alu_result  in  64  ALU result / effective address.
- mem_load_data  in  64  raw aligned doubleword from data memory.
- mem_funct3  in  3  load size: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 treated as LD.
- ll_valid  in  1  long-latency result valid.
- ll_rd  in  5  long-latency destination register.
- ll_data  in  64  long-latency result.
- ll_ready  out  1  long-latency result accepted this cycle.
- wb_stall  out  1  pipeline must hold the MEM entry this cycle.
- regwrite  out  1  to bank write enable.
- register3  out  5  to bank write address.
- datain  out  64  to bank write data.

Behaviour:
- Reset (rst_n=0, async):
  - regwrite=0, register3=0, datain=0, starvation counter=0, wb_stall=0.
  - ll_ready=0 while rst_n=0.
  - A reset mid-operation drops any in-flight write.
- Pipeline write candidate (pw): mem_valid & mem_regwrite & (mem_rd!=0) & !wb_stall.
  - Entries with rd=0 or regwrite=0 are consumed without taking the port.
- ll_ready = rst_n & !pw (combinational).
- Output register update at each posedge:
  - If pw: regwrite=1, register3=mem_rd, datain=formatted result.
  - Else if ll_valid: register3=ll_rd, datain=ll_data, regwrite=(ll_rd!=0). An LL result with rd=0 is handshaken and discarded.
  - Else: regwrite=0; register3/datain hold their previous values.
- Latency: exactly 1 cycle from capture to regwrite high; the bank commits on the following edge.
- Pipeline has priority over LL every cycle unless wb_stall=1.
- Starvation counter:
  - Increments each cycle ll_valid & !ll_ready, saturating at STARVE_LIMIT.
  - Clears on any LL handshake or when ll_valid=0.
- wb_stall = (counter==STARVE_LIMIT), decoded from the register.
  - In that cycle pw is forced 0, so ll_ready=1, the LL result is written and the counter clears.
  - The MEM entry is not captured; upstream holds it and it is captured the next cycle.
- Load formatting (mem_memtoreg=1):
  - byte lane = mem_alu_result[2:0].
  - B uses bits [2:0]; H uses [2:1]; W uses [2]; D ignores all three bits.
  - Misaligned low bits are ignored.
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend.
- mem_memtoreg=0: datain = mem_alu_result.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds inputs rs1, rs2 (5 each) and bank_dout1, bank_dout2 (64 each); adds outputs fwd_dout1, fwd_dout2 (64 each).
  - fwd_doutN = datain when regwrite & (register3==rsN) & (rsN!=0); otherwise bank_doutN.
  - Covers the write/read-same-cycle hazard in decode.
- Not defined: these ports do not exist; decode reads the bank directly.

Test Plan:
- Reset, then release with mem_valid=0, ll_valid=0 -> regwrite=0, register3=0, datain=0, ll_ready=1, wb_stall=0.
- ALU write, mem_rd=5, mem_alu_result=64'h1234, memtoreg=0 -> next cycle regwrite=1, register3=5, datain=64'h1234; mem_rd=0 instead -> regwrite=0.
- Loads with mem_load_data=64'h80FF_7F01_8002_00F0, addr_lo=1:
  - LB -> 64'h0000_0000_0000_0000 (byte 0x00).
  - addr_lo=0 LB -> 64'hFFFF_FFFF_FFFF_FFF0.
  - LBU -> 64'hF0.
  - addr_lo=2 LH -> 64'hFFFF_FFFF_FFFF_8002.
  - addr_lo=4 LWU -> 64'h80FF_7F01.
- Both sources valid with pipeline rd=3 and ll_rd=7 -> pipeline written first and ll_ready=0; the cycle after, with no pipeline write, ll_ready=1 and register3=7.
- STARVE_LIMIT=8, continuous pipeline writes plus ll_valid -> wb_stall=1 on the 9th cycle, ll_ready=1, LL result written, counter clears, held MEM entry written the next cycle.
- WB_BYPASS_EN defined, regwrite=1, register3=9, datain=64'hAA, rs1=9, bank_dout1=0 -> fwd_dout1=64'hAA; rs1=0 -> fwd_dout1=bank_dout1.

Source files
------------

// File: rtl/wb_stage_if.sv
// Writeback-stage bus: MEM-stage entry, long-latency result handshake, and register-bank write port.
interface wb_stage_if;
  logic        mem_valid;
  logic        mem_regwrite;
  logic        mem_memtoreg;
  logic [4:0]  mem_rd;
  logic [63:0] mem_alu_result;
  logic [63:0] mem_load_data;
  logic [2:0]  mem_funct3;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [63:0] ll_data;
  logic        ll_ready;
  logic        wb_stall;
  logic        regwrite;
  logic [4:0]  register3;
  logic [63:0] datain;

  modport master (
    output mem_valid, mem_regwrite, mem_memtoreg, mem_rd, mem_alu_result,
           mem_load_data, mem_funct3, ll_valid, ll_rd, ll_data,
    input  ll_ready, wb_stall, regwrite, register3, datain
  );

  modport slave (
    input  mem_valid, mem_regwrite, mem_memtoreg, mem_rd, mem_alu_result,
           mem_load_data, mem_funct3, ll_valid, ll_rd, ll_data,
    output ll_ready, wb_stall, regwrite, register3, datain
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: load formatting and write-port arbitration between pipeline and long-latency unit.
// Optional macro WB_BYPASS_EN adds same-cycle write/read forwarding for the decode read ports.
module wb_stage #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_stage_if.slave   bus
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [63:0] bank_dout1,
  input  logic [63:0] bank_dout2,
  output logic [63:0] fwd_dout1,
  output logic [63:0] fwd_dout2
`endif
);

  function automatic logic [63:0] fmt_load(input logic [63:0] d, input logic [2:0] a,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    logic [63:0] r;
    b = d[{a, 3'b000} +: 8];
    h = d[{a[2:1], 4'b0000} +: 16];
    w = d[{a[2], 5'b00000} +: 32];
    case (f3)
      3'b000:  r = {{56{b[7]}}, b};
      3'b001:  r = {{48{h[15]}}, h};
      3'b010:  r = {{32{w[31]}}, w};
      3'b100:  r = {56'd0, b};
      3'b101:  r = {48'd0, h};
      3'b110:  r = {32'd0, w};
      default: r = d;
    endcase
    return r;
  endfunction

  logic        regwrite_p1;
  logic [4:0]  rd_p1;
  logic [63:0] data_p1;
  logic [7:0]  starve_cnt;
  logic        stall;
  logic        pw;
  logic        ll_ready_c;
  logic [63:0] pipe_data_p0;

  assign stall        = (starve_cnt == 8'(STARVE_LIMIT));
  assign pw           = bus.mem_valid & bus.mem_regwrite & (bus.mem_rd != 5'd0) & ~stall;
  assign ll_ready_c   = rst_n & ~pw;
  assign pipe_data_p0 = bus.mem_memtoreg
                      ? fmt_load(bus.mem_load_data, bus.mem_alu_result[2:0], bus.mem_funct3)
                      : bus.mem_alu_result;

  // MEM -> WB register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_p1 <= 1'b0;
      rd_p1       <= 5'd0;
      data_p1     <= 64'd0;
      starve_cnt  <= 8'd0;
    end else begin
      if (pw) begin
        regwrite_p1 <= 1'b1;
        rd_p1       <= bus.mem_rd;
        data_p1     <= pipe_data_p0;
      end else if (bus.ll_valid) begin
        regwrite_p1 <= (bus.ll_rd != 5'd0);
        rd_p1       <= bus.ll_rd;
        data_p1     <= bus.ll_data;
      end else begin
        regwrite_p1 <= 1'b0;
      end

      // Only a refused LL result ages; a handshake or an idle unit restarts the count.
      if (bus.ll_valid && !ll_ready_c) begin
        if (starve_cnt != 8'(STARVE_LIMIT))
          starve_cnt <= starve_cnt + 8'd1;
      end else begin
        starve_cnt <= 8'd0;
      end
    end
  end

  assign bus.ll_ready  = ll_ready_c;
  assign bus.wb_stall  = stall;
  assign bus.regwrite  = regwrite_p1;
  assign bus.register3 = rd_p1;
  assign bus.datain    = data_p1;

`ifdef WB_BYPASS_EN
  assign fwd_dout1 = (regwrite_p1 && (rd_p1 == rs1) && (rs1 != 5'd0)) ? data_p1 : bank_dout1;
  assign fwd_dout2 = (regwrite_p1 && (rd_p1 == rs2) && (rs2 != 5'd0)) ? data_p1 : bank_dout2;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, ALU/load writeback, arbitration, starvation guard, optional bypass.
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  wb_stage_if bus();

`ifdef WB_BYPASS_EN
  logic [4:0]  rs1 = '0, rs2 = '0;
  logic [63:0] bank_dout1 = '0, bank_dout2 = '0;
  logic [63:0] fwd_dout1, fwd_dout2;
`endif

  wb_stage #(.STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef WB_BYPASS_EN
    ,
    .rs1        (rs1),
    .rs2        (rs2),
    .bank_dout1 (bank_dout1),
    .bank_dout2 (bank_dout2),
    .fwd_dout1  (fwd_dout1),
    .fwd_dout2  (fwd_dout2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  lo;
    logic [2:0]  f3;
    logic [63:0] res;
  } ld_vec_t;

  ld_vec_t lv[9];

  initial begin
    lv[0] = '{3'd1, 3'b000, 64'h0000_0000_0000_0000};
    lv[1] = '{3'd0, 3'b000, 64'hFFFF_FFFF_FFFF_FFF0};
    lv[2] = '{3'd0, 3'b100, 64'h0000_0000_0000_00F0};
    lv[3] = '{3'd2, 3'b001, 64'hFFFF_FFFF_FFFF_8002};
    lv[4] = '{3'd4, 3'b110, 64'h0000_0000_80FF_7F01};
    lv[5] = '{3'd6, 3'b010, 64'hFFFF_FFFF_80FF_7F01};
    lv[6] = '{3'd7, 3'b101, 64'h0000_0000_0000_80FF};
    lv[7] = '{3'd5, 3'b011, 64'h80FF_7F01_8002_00F0};
    lv[8] = '{3'd3, 3'b111, 64'h80FF_7F01_8002_00F0};

    bus.mem_valid = 0; bus.mem_regwrite = 0; bus.mem_memtoreg = 0; bus.mem_rd = '0;
    bus.mem_alu_result = '0; bus.mem_load_data = '0; bus.mem_funct3 = '0;
    bus.ll_valid = 0; bus.ll_rd = '0; bus.ll_data = '0;

    // reset
    tick(); tick();
    chk("rst_ll_ready", {63'd0, bus.ll_ready}, 64'd0);
    chk("rst_regwrite", {63'd0, bus.regwrite}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_regwrite", {63'd0, bus.regwrite}, 64'd0);
    chk("idle_register3", {59'd0, bus.register3}, 64'd0);
    chk("idle_datain", bus.datain, 64'd0);
    chk("idle_ll_ready", {63'd0, bus.ll_ready}, 64'd1);
    chk("idle_wb_stall", {63'd0, bus.wb_stall}, 64'd0);

    // ALU result write, then rd=0 entry consumed without a write
    bus.mem_valid = 1; bus.mem_regwrite = 1; bus.mem_rd = 5'd5; bus.mem_alu_result = 64'h1234;
    tick();
    chk("alu_regwrite", {63'd0, bus.regwrite}, 64'd1);
    chk("alu_register3", {59'd0, bus.register3}, 64'd5);
    chk("alu_datain", bus.datain, 64'h1234);
    bus.mem_rd = 5'd0; bus.mem_alu_result = 64'h9999;
    tick();
    chk("rd0_regwrite", {63'd0, bus.regwrite}, 64'd0);
    chk("rd0_register3_hold", {59'd0, bus.register3}, 64'd5);
    chk("rd0_datain_hold", bus.datain, 64'h1234);

    // load formatting
    bus.mem_memtoreg = 1; bus.mem_rd = 5'd10;
    bus.mem_load_data = 64'h80FF_7F01_8002_00F0;
    for (int i = 0; i < 9; i++) begin
      bus.mem_alu_result = {61'h100, lv[i].lo};
      bus.mem_funct3 = lv[i].f3;
      tick();
      chk($sformatf("load%0d_f3_%0d_lo_%0d", i, lv[i].f3, lv[i].lo), bus.datain, lv[i].res);
    end
    bus.mem_memtoreg = 0;

    // both sources valid: pipeline first, LL next
    bus.mem_rd = 5'd3; bus.mem_alu_result = 64'h33;
    bus.ll_valid = 1; bus.ll_rd = 5'd7; bus.ll_data = 64'h77;
    #1;
    chk("both_ll_ready", {63'd0, bus.ll_ready}, 64'd0);
    tick();
    chk("both_register3", {59'd0, bus.register3}, 64'd3);
    chk("both_datain", bus.datain, 64'h33);
    bus.mem_valid = 0;
    #1;
    chk("ll_ready_free", {63'd0, bus.ll_ready}, 64'd1);
    tick();
    chk("ll_register3", {59'd0, bus.register3}, 64'd7);
    chk("ll_datain", bus.datain, 64'h77);
    chk("ll_regwrite", {63'd0, bus.regwrite}, 64'd1);

    // LL result to rd=0 is accepted and discarded
    bus.ll_rd = 5'd0; bus.ll_data = 64'hDEAD;
    tick();
    chk("ll_rd0_regwrite", {63'd0, bus.regwrite}, 64'd0);
    bus.ll_valid = 0;
    tick();

    // starvation guard
    bus.mem_valid = 1; bus.mem_rd = 5'd4;
    bus.ll_valid = 1; bus.ll_rd = 5'd12; bus.ll_data = 64'hCC;
    for (int i = 1; i <= 8; i++) begin
      bus.mem_alu_result = 64'(100 + i);
      #1;
      chk($sformatf("starve%0d_wb_stall", i), {63'd0, bus.wb_stall}, 64'd0);
      chk($sformatf("starve%0d_ll_ready", i), {63'd0, bus.ll_ready}, 64'd0);
      tick();
      chk($sformatf("starve%0d_datain", i), bus.datain, 64'(100 + i));
    end
    bus.mem_alu_result = 64'd109;
    #1;
    chk("stall_wb_stall", {63'd0, bus.wb_stall}, 64'd1);
    chk("stall_ll_ready", {63'd0, bus.ll_ready}, 64'd1);
    tick();
    chk("stall_register3", {59'd0, bus.register3}, 64'd12);
    chk("stall_datain", bus.datain, 64'hCC);
    chk("stall_cleared", {63'd0, bus.wb_stall}, 64'd0);
    bus.ll_valid = 0;
    tick();
    chk("held_register3", {59'd0, bus.register3}, 64'd4);
    chk("held_datain", bus.datain, 64'd109);

`ifdef WB_BYPASS_EN
    bus.mem_rd = 5'd9; bus.mem_alu_result = 64'hAA;
    tick();
    rs1 = 5'd9; bank_dout1 = 64'd0; rs2 = 5'd8; bank_dout2 = 64'h22;
    #1;
    chk("fwd1_hit", fwd_dout1, 64'hAA);
    chk("fwd2_miss", fwd_dout2, 64'h22);
    rs1 = 5'd0; bank_dout1 = 64'h55;
    #1;
    chk("fwd1_rs0", fwd_dout1, 64'h55);
`endif

    // reset mid-operation drops the in-flight write
    bus.mem_rd = 5'd6; bus.mem_alu_result = 64'h66;
    tick();
    chk("pre_rst_regwrite", {63'd0, bus.regwrite}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_regwrite", {63'd0, bus.regwrite}, 64'd0);
    chk("mid_rst_datain", bus.datain, 64'd0);
    chk("mid_rst_ll_ready", {63'd0, bus.ll_ready}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
